// File: rtl/jtopl_wrq_if.sv
// Bus bundle between the host CPU write port, the write queue and the jtopl core.
// The slave side is the queue; the master side drives the CPU bus and observes the OPL bus.
interface jtopl_wrq_if;
    logic [7:0] cpu_din;
    logic       cpu_addr;
    logic       cpu_cs_n;
    logic       cpu_wr_n;
    logic       wait_n;
    logic       empty;
    logic       ovf;
    logic [7:0] opl_din;
    logic       opl_addr;
    logic       opl_cs_n;
    logic       opl_wr_n;

    modport master (
        output cpu_din, cpu_addr, cpu_cs_n, cpu_wr_n,
        input  wait_n, empty, ovf, opl_din, opl_addr, opl_cs_n, opl_wr_n
    );

    modport slave (
        input  cpu_din, cpu_addr, cpu_cs_n, cpu_wr_n,
        output wait_n, empty, ovf, opl_din, opl_addr, opl_cs_n, opl_wr_n
    );
endinterface

// File: rtl/jtopl_wrq.sv
// jtopl_wrq: queues CPU writes to the OPL ports and replays them paced by OPL recovery times.
// Macro JTOPL_WRQ_WAIT_EN: stall the CPU on a full queue instead of dropping the write.
module jtopl_wrq #(
    parameter int AW        = 3,
    parameter int ADDR_WAIT = 12,
    parameter int DATA_WAIT = 84
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    jtopl_wrq_if.slave bus
);
    localparam int DEPTH = 1 << AW;
    localparam int MAXW  = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
    localparam int CW    = (MAXW < 1) ? 1 : $clog2(MAXW + 1);

    typedef enum logic [1:0] {IDLE, STROBE, RECOV} state_t;

    state_t          state_q, state_d;
    logic [8:0]      mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [AW:0]     cnt_q, cnt_d;
    logic [CW-1:0]   rc_q, rc_d;
    logic [7:0]      din_q, din_d;
    logic            addr_q, addr_d;
    logic            strb_n_q, strb_n_d;
    logic            wr_q, ovf_q, ovf_d;
    logic            wr, wr_edge, full, push, pop;

    assign wr      = !bus.cpu_cs_n && !bus.cpu_wr_n;
    assign wr_edge = wr && !wr_q;
    // Count never exceeds DEPTH, so its top bit alone marks a full queue.
    assign full    = cnt_q[AW];
    assign pop     = (state_q == IDLE) && (cnt_q != '0);

`ifdef JTOPL_WRQ_WAIT_EN
    logic pend_q, push_req;

    // A write that met a full queue stays pending while the CPU keeps the strobe low.
    assign push_req   = wr && (wr_edge || pend_q);
    assign push       = push_req && (!full || pop);
    assign bus.wait_n = !(full && wr);
    assign ovf_d      = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= 1'b0;
        else        pend_q <= push_req && !push;
    end
`else
    assign push       = wr_edge && (!full || pop);
    assign bus.wait_n = 1'b1;
    assign ovf_d      = ovf_q || (wr_edge && full && !pop);
`endif

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {bus.cpu_addr, bus.cpu_din};
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
        else if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
    end

    always_comb begin
        state_d  = state_q;
        rc_d     = rc_q;
        din_d    = din_q;
        addr_d   = addr_q;
        strb_n_d = strb_n_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    {addr_d, din_d} = mem_q[rptr_q];
                    strb_n_d        = 1'b0;
                    state_d         = STROBE;
                end
            end
            STROBE: begin
                if (cen) begin
                    strb_n_d = 1'b1;
                    rc_d     = addr_q ? CW'(DATA_WAIT) : CW'(ADDR_WAIT);
                    state_d  = RECOV;
                end
            end
            RECOV: begin
                // A zero recovery still spends one clk here.
                if (rc_q == '0) begin
                    state_d = IDLE;
                end else if (cen) begin
                    rc_d = rc_q - CW'(1);
                    if (rc_q == CW'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            rc_q     <= '0;
            din_q    <= '0;
            addr_q   <= 1'b0;
            strb_n_q <= 1'b1;
            wr_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rc_q     <= rc_d;
            din_q    <= din_d;
            addr_q   <= addr_d;
            strb_n_q <= strb_n_d;
            wr_q     <= wr;
            ovf_q    <= ovf_d;
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
        end
    end

    assign bus.empty    = (cnt_q == '0) && (state_q == IDLE);
    assign bus.ovf      = ovf_q;
    assign bus.opl_din  = din_q;
    assign bus.opl_addr = addr_q;
    assign bus.opl_cs_n = strb_n_q;
    assign bus.opl_wr_n = strb_n_q;
endmodule
